vga_overlay_timing: RTL and testbench

Parametrised successor to the fixed 640x480 VGA output stage. It generates programmable raster timing (counters, syncs, blank) and a memory-latency-aligned output pipeline for upstream RGB pixels. It composites a configurable overlay of N markers plus an optional centre crosshair. Marker coordinates are frame-synchronised so the overlay never tears. It sits between the frame-buffer read path and the VGA DAC pins.

---
 rtl/vga_overlay_timing_if.sv | 38 +++
 rtl/vga_overlay_timing.sv | 168 ++++++++++++++++
 tb/tb_vga_overlay_timing.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_overlay_timing_if.sv
// Marker/pixel inputs and raster/DAC outputs of the VGA overlay timing stage.
// The slave side is the timing block; the master side is its environment.
interface vga_overlay_timing_if #(
    parameter int unsigned HW     = 10,
    parameter int unsigned VW     = 10,
    parameter int unsigned N_MARK = 4
);
    logic [N_MARK*HW-1:0] mark_x;
    logic [N_MARK*VW-1:0] mark_y;
    logic [N_MARK-1:0]    mark_en;
    logic                 cross_en;
    logic [23:0]          rgb_in;
    logic [HW-1:0]        hcount;
    logic [VW-1:0]        vcount;
    logic                 frame_start;
    logic                 line_start;
    logic [7:0]           vga_red;
    logic [7:0]           vga_green;
    logic [7:0]           vga_blue;
    logic                 vga_hsync;
    logic                 vga_vsync;
    logic                 vga_blank_b;
    logic                 vga_sync_b;

    modport master (
        output mark_x, mark_y, mark_en, cross_en, rgb_in,
        input  hcount, vcount, frame_start, line_start,
        input  vga_red, vga_green, vga_blue,
        input  vga_hsync, vga_vsync, vga_blank_b, vga_sync_b
    );

    modport slave (
        input  mark_x, mark_y, mark_en, cross_en, rgb_in,
        output hcount, vcount, frame_start, line_start,
        output vga_red, vga_green, vga_blue,
        output vga_hsync, vga_vsync, vga_blank_b, vga_sync_b
    );
endinterface

// File: rtl/vga_overlay_timing.sv
// Programmable VGA raster timing with a latency-matched output pipeline that
// composites frame-synchronised markers and an optional crosshair over rgb_in.
module vga_overlay_timing #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 11,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 31,
    parameter int unsigned HW        = 10,
    parameter int unsigned VW        = 10,
    parameter int unsigned DELAY     = 7,
    parameter int unsigned N_MARK    = 4,
    parameter int unsigned MARK_MODE = 0,
    parameter logic [23:0] OVL_RGB   = 24'hFFFFFF
) (
    input  logic                 clock,
    input  logic                 reset,
    vga_overlay_timing_if.slave  bus
);
    localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_FIRST  = H_ACTIVE + H_FP;
    localparam int unsigned HS_LAST   = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int unsigned VS_FIRST  = V_ACTIVE + V_FP;
    localparam int unsigned VS_LAST   = V_ACTIVE + V_FP + V_SYNC - 1;
    localparam logic signed [HW:0] DX_LIM = (HW+1)'(2);
    localparam logic signed [VW:0] DY_LIM = (VW+1)'(2);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          h_last, v_last;

    logic [N_MARK*HW-1:0] mx_q;
    logic [N_MARK*VW-1:0] my_q;
    logic [N_MARK-1:0]    men_q;
    logic                 cross_q;

    logic hit_raw, hs_raw, vs_raw, blank_raw;
    logic [HW-1:0]        mx;
    logic [VW-1:0]        my;
    logic signed [HW:0]   dx;
    logic signed [VW:0]   dy;
    logic                 near;

    logic [DELAY-1:0] hit_dly_q, hs_dly_q, vs_dly_q, blank_dly_q;
    logic [23:0]      rgb_q, rgb_d;
    logic             hsync_q, vsync_q, blank_b_q;
    logic             line_start_c;

    // Raster counters: hcount wraps every line, vcount every frame
    always_comb begin
        h_last = (h_q == HW'(H_TOTAL - 1));
        v_last = (v_q == VW'(V_TOTAL - 1));
        h_d    = h_last ? '0 : h_q + HW'(1);
        v_d    = v_q;
        if (h_last) begin
            v_d = v_last ? '0 : v_q + VW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // Marker shadows load on the last pixel of a frame so the overlay never tears
    always_ff @(posedge clock) begin
        if (reset) begin
            mx_q    <= '0;
            my_q    <= '0;
            men_q   <= '0;
            cross_q <= 1'b0;
        end else if (h_last && v_last) begin
            mx_q    <= bus.mark_x;
            my_q    <= bus.mark_y;
            men_q   <= bus.mark_en;
            cross_q <= bus.cross_en;
        end
    end

    always_comb begin
        hs_raw    = !((h_q >= HW'(HS_FIRST)) && (h_q <= HW'(HS_LAST)));
        vs_raw    = !((v_q >= VW'(VS_FIRST)) && (v_q <= VW'(VS_LAST)));
        blank_raw = (h_q >= HW'(H_ACTIVE)) || (v_q >= VW'(V_ACTIVE));
    end

    // Hit test on undelayed counters; box mode uses widened signed deltas so edges clip
    always_comb begin
        hit_raw = cross_q && ((h_q == HW'(H_ACTIVE / 2)) || (v_q == VW'(V_ACTIVE / 2)));
        mx      = '0;
        my      = '0;
        dx      = '0;
        dy      = '0;
        near    = 1'b0;
        for (int i = 0; i < int'(N_MARK); i++) begin
            mx = mx_q[i*HW +: HW];
            my = my_q[i*VW +: VW];
            if (MARK_MODE == 0) begin
                near = (h_q == mx) || (v_q == my);
            end else begin
                dx   = $signed({1'b0, h_q}) - $signed({1'b0, mx});
                dy   = $signed({1'b0, v_q}) - $signed({1'b0, my});
                near = (dx >= -DX_LIM) && (dx <= DX_LIM) && (dy >= -DY_LIM) && (dy <= DY_LIM);
            end
            hit_raw = hit_raw | (men_q[i] & near);
        end
    end

    // Delay lines aligning control with rgb_in; reset to blanked, syncs inactive
    always_ff @(posedge clock) begin
        if (reset) begin
            hit_dly_q   <= '0;
            hs_dly_q    <= '1;
            vs_dly_q    <= '1;
            blank_dly_q <= '1;
        end else begin
            hit_dly_q   <= {hit_dly_q[DELAY-2:0], hit_raw};
            hs_dly_q    <= {hs_dly_q[DELAY-2:0], hs_raw};
            vs_dly_q    <= {vs_dly_q[DELAY-2:0], vs_raw};
            blank_dly_q <= {blank_dly_q[DELAY-2:0], blank_raw};
        end
    end

    always_comb begin
        rgb_d = bus.rgb_in;
        if (blank_dly_q[DELAY-1]) begin
            rgb_d = '0;
        end else if (hit_dly_q[DELAY-1]) begin
            rgb_d = OVL_RGB;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rgb_q     <= '0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            blank_b_q <= 1'b0;
        end else begin
            rgb_q     <= rgb_d;
            hsync_q   <= hs_dly_q[DELAY-1];
            vsync_q   <= vs_dly_q[DELAY-1];
            blank_b_q <= !blank_dly_q[DELAY-1];
        end
    end

    // Start pulses decode the counter registers, held low while reset is asserted
    assign line_start_c    = (h_q == '0) && !reset;
    assign bus.line_start  = line_start_c;
    assign bus.frame_start = line_start_c && (v_q == '0);
    assign bus.hcount      = h_q;
    assign bus.vcount      = v_q;
    assign bus.vga_red     = rgb_q[23:16];
    assign bus.vga_green   = rgb_q[15:8];
    assign bus.vga_blue    = rgb_q[7:0];
    assign bus.vga_hsync   = hsync_q;
    assign bus.vga_vsync   = vsync_q;
    assign bus.vga_blank_b = blank_b_q;
    assign bus.vga_sync_b  = 1'b1;
endmodule

// File: tb/tb_vga_overlay_timing.sv
// Scoreboard bench: a raster-position model predicts every pin each cycle for a
// line-mode and a box-mode instance sharing one randomized stimulus stream.
module tb_vga_overlay_timing;
    localparam int HA = 16, HF = 2, HSW = 3, HBP = 3;
    localparam int VA = 12, VF = 1, VSW = 2, VBP = 2;
    localparam int HT = HA + HF + HSW + HBP;
    localparam int VT = VA + VF + VSW + VBP;
    localparam int FT = HT * VT;
    localparam int HW = 6, VW = 6, DLY = 3, N = 2;
    localparam logic [23:0] OVL = 24'hA5C3E7;
    localparam int VEC_W = HW + VW + 2 + 24 + 4;

    typedef struct packed {
        logic [N-1:0][HW-1:0] x;
        logic [N-1:0][VW-1:0] y;
        logic [N-1:0]         en;
        logic                 cr;
    } shadow_t;

    typedef struct packed {
        logic [31:0]   tag;
        logic [HW-1:0] h;
        logic [VW-1:0] v;
        logic          ls, fs;
        logic [23:0]   rgb0, rgb1;
        logic          hs, vs, bb;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   k;
    bit   rst_active;
    int   vectors = 0;
    int   fails = 0;
    exp_t sbq[$];
    shadow_t shadows[int];

    vga_overlay_timing_if #(.HW(HW), .VW(VW), .N_MARK(N)) if0 ();
    vga_overlay_timing_if #(.HW(HW), .VW(VW), .N_MARK(N)) if1 ();

    assign if1.mark_x   = if0.mark_x;
    assign if1.mark_y   = if0.mark_y;
    assign if1.mark_en  = if0.mark_en;
    assign if1.cross_en = if0.cross_en;
    assign if1.rgb_in   = if0.rgb_in;

    vga_overlay_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VBP),
        .HW(HW), .VW(VW), .DELAY(DLY), .N_MARK(N), .MARK_MODE(0), .OVL_RGB(OVL)
    ) u_line (.clock(clk), .reset(reset), .bus(if0));

    vga_overlay_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VBP),
        .HW(HW), .VW(VW), .DELAY(DLY), .N_MARK(N), .MARK_MODE(1), .OVL_RGB(OVL)
    ) u_box (.clock(clk), .reset(reset), .bus(if1));

    always #5 clk = ~clk;

    function automatic bit model_hit(int h, int v, shadow_t s, int mode);
        bit r;
        r = s.cr && (h == HA / 2 || v == VA / 2);
        for (int i = 0; i < N; i++) begin
            int dx, dy;
            dx = h - int'(s.x[i]);
            dy = v - int'(s.y[i]);
            if (s.en[i]) begin
                if (mode == 0) r = r | (dx == 0) | (dy == 0);
                else           r = r | (dx >= -2 && dx <= 2 && dy >= -2 && dy <= 2);
            end
        end
        return r;
    endfunction

    // Expected pins for cycle kk+1: counters of kk+1, pixel of position kk-DLY, rgb_in of kk
    function automatic exp_t make_exp(int kk, logic [23:0] rgb);
        exp_t    e;
        shadow_t s;
        int      p, h, v, nk;
        bit      blank;
        nk = kk + 1;
        p  = kk - DLY;
        e  = '0;
        e.tag = 32'(nk);
        e.h   = HW'(nk % HT);
        e.v   = VW'((nk / HT) % VT);
        e.ls  = (nk % HT) == 0;
        e.fs  = (nk % FT) == 0;
        e.hs  = 1'b1;
        e.vs  = 1'b1;
        e.bb  = 1'b0;
        if (p >= 0) begin
            h = p % HT;
            v = (p / HT) % VT;
            s = shadows.exists(p / FT) ? shadows[p / FT] : '0;
            blank = (h >= HA) || (v >= VA);
            e.hs = !(h >= HA + HF && h < HA + HF + HSW);
            e.vs = !(v >= VA + VF && v < VA + VF + VSW);
            e.bb = !blank;
            if (!blank) begin
                e.rgb0 = model_hit(h, v, s, 0) ? OVL : rgb;
                e.rgb1 = model_hit(h, v, s, 1) ? OVL : rgb;
            end
        end
        return e;
    endfunction

    task automatic set_mark(int i, int x, int y, bit en);
        if0.mark_x[i*HW +: HW] = HW'(x);
        if0.mark_y[i*VW +: VW] = VW'(y);
        if0.mark_en[i]         = en;
    endtask

    task automatic run_cycle();
        shadow_t s;
        if0.rgb_in = 24'($urandom());
        if (k % FT == FT - 1) begin
            s.x  = if0.mark_x;
            s.y  = if0.mark_y;
            s.en = if0.mark_en;
            s.cr = if0.cross_en;
            shadows[k / FT + 1] = s;
        end
        sbq.push_back(make_exp(k, if0.rgb_in));
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic release_reset();
        reset      = 1'b0;
        rst_active = 1'b0;
        k          = 0;
        shadows.delete();
        sbq.push_back(make_exp(-1, 24'h0));
    endtask

    task automatic compare(string name, logic [VEC_W-1:0] act, logic [VEC_W-1:0] req);
        vectors++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, k, act, req);
        end
    endtask

    // Monitor: reset-state checks while reset is held, else pop the entry due this cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_active) begin
                compare("reset_line", {if0.hcount, if0.vcount, if0.line_start, if0.frame_start,
                        if0.vga_red, if0.vga_green, if0.vga_blue, if0.vga_hsync, if0.vga_vsync,
                        if0.vga_blank_b, if0.vga_sync_b}, {HW'(0), VW'(0), 2'b00, 24'h0, 4'b1101});
                compare("reset_box", {if1.hcount, if1.vcount, if1.line_start, if1.frame_start,
                        if1.vga_red, if1.vga_green, if1.vga_blue, if1.vga_hsync, if1.vga_vsync,
                        if1.vga_blank_b, if1.vga_sync_b}, {HW'(0), VW'(0), 2'b00, 24'h0, 4'b1101});
            end else if (sbq.size() > 0 && int'(sbq[0].tag) == k) begin
                e = sbq.pop_front();
                compare("pins_line", {if0.hcount, if0.vcount, if0.line_start, if0.frame_start,
                        if0.vga_red, if0.vga_green, if0.vga_blue, if0.vga_hsync, if0.vga_vsync,
                        if0.vga_blank_b, if0.vga_sync_b},
                        {e.h, e.v, e.ls, e.fs, e.rgb0, e.hs, e.vs, e.bb, 1'b1});
                compare("pins_box", {if1.hcount, if1.vcount, if1.line_start, if1.frame_start,
                        if1.vga_red, if1.vga_green, if1.vga_blue, if1.vga_hsync, if1.vga_vsync,
                        if1.vga_blank_b, if1.vga_sync_b},
                        {e.h, e.v, e.ls, e.fs, e.rgb1, e.hs, e.vs, e.bb, 1'b1});
            end
        end
    end

    initial begin
        reset         = 1'b1;
        rst_active    = 1'b0;
        k             = 0;
        if0.mark_x    = '0;
        if0.mark_y    = '0;
        if0.mark_en   = '0;
        if0.cross_en  = 1'b0;
        if0.rgb_in    = '0;
        @(posedge clk);
        #1 rst_active = 1'b1;
        @(posedge clk);
        #1;
        release_reset();

        // Pass-through with no overlay
        repeat (2 * FT) run_cycle();

        // Line marker plus crosshair, then a mid-frame x move that must wait a frame
        set_mark(0, 5, 4, 1'b1);
        set_mark(1, 40, 50, 1'b1);
        if0.cross_en = 1'b1;
        repeat (FT) run_cycle();
        while (k % FT != 6 * HT) run_cycle();
        set_mark(0, 9, 4, 1'b1);
        repeat (2 * FT) run_cycle();

        // Box near the top-left corner and at the right edge of the active area
        set_mark(0, 1, 1, 1'b1);
        set_mark(1, HA - 1, VA - 1, 1'b1);
        if0.cross_en = 1'b0;
        repeat (2 * FT) run_cycle();

        // Randomized markers changing at arbitrary points in the frame
        for (int c = 0; c < 6 * FT; c++) begin
            if ($urandom_range(0, 39) == 0) begin
                for (int i = 0; i < N; i++) begin
                    set_mark(i, int'($urandom_range(0, HT + 2)), int'($urandom_range(0, VT + 2)),
                             1'($urandom_range(0, 1)));
                end
                if0.cross_en = 1'($urandom_range(0, 1));
            end
            run_cycle();
        end

        // Mid-frame reset for three cycles, then restart from 0,0
        while (k % FT != 4 * HT + 5) run_cycle();
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1 rst_active = 1'b1;
        end
        release_reset();
        set_mark(0, 3, 2, 1'b1);
        repeat (2 * FT + 10) run_cycle();

        @(negedge clk);
        #1;
        vectors++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL drain pending=%0d expected=0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
